// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes, debounces and auto-repeats push buttons.
// Ports: clk, rst_n (async low), btn_raw in; btn_level/press/release, btn_any_press out.
module btn_conditioner #(
  parameter int               N_BTN         = 4,
  parameter int               DB_CYCLES     = 2,
  parameter int               REPEAT_DELAY  = 48,
  parameter int               REPEAT_PERIOD = 10,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = {N_BTN{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             btn_any_press
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [RP_W-1:0] DLY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PER_LAST = RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } st_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] release_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    localparam bit REP_EN = REPEAT_MASK[i];

    st_t             st_q, st_d;
    logic [DB_W-1:0] db_q, db_d;
    logic [RP_W-1:0] rp_q, rp_d;
    logic            fd_q, fd_d;
    logic            lvl_d, prs_d, rel_d;
    logic            s;

    assign s = sync2[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q <= RELEASED;
        db_q <= '0;
        rp_q <= '0;
        fd_q <= 1'b0;
      end else begin
        st_q <= st_d;
        db_q <= db_d;
        rp_q <= rp_d;
        fd_q <= fd_d;
      end
    end

    always_comb begin
      st_d  = st_q;
      db_d  = db_q;
      rp_d  = rp_q;
      fd_d  = fd_q;
      lvl_d = btn_level[i];
      prs_d = 1'b0;
      rel_d = 1'b0;
      unique case (st_q)
        RELEASED: begin
          lvl_d = 1'b0;
          if (s) begin
            if (DB_CYCLES == 1) begin
              st_d  = PRESSED;
              db_d  = '0;
              rp_d  = '0;
              fd_d  = 1'b0;
              lvl_d = 1'b1;
              prs_d = 1'b1;
            end else begin
              st_d = PRESS_WAIT;
              db_d = DB_ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            st_d = RELEASED;
            db_d = '0;
          end else if (db_q == DB_LAST) begin
            st_d  = PRESSED;
            db_d  = '0;
            rp_d  = '0;
            fd_d  = 1'b0;
            lvl_d = 1'b1;
            prs_d = 1'b1;
          end else begin
            db_d = db_q + DB_ONE;
          end
        end
        PRESSED: begin
          if (!s) begin
            if (DB_CYCLES == 1) begin
              st_d  = RELEASED;
              db_d  = '0;
              rp_d  = '0;
              fd_d  = 1'b0;
              lvl_d = 1'b0;
              rel_d = 1'b1;
            end else begin
              st_d = RELEASE_WAIT;
              db_d = DB_ONE;
            end
          end else if (REP_EN) begin
            // first repeat waits the long delay, later ones the period
            if (rp_q == (fd_q ? PER_LAST : DLY_LAST)) begin
              rp_d  = '0;
              fd_d  = 1'b1;
              prs_d = 1'b1;
            end else begin
              rp_d = rp_q + RP_W'(1);
            end
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            st_d = PRESSED;
            db_d = '0;
          end else if (db_q == DB_LAST) begin
            st_d  = RELEASED;
            db_d  = '0;
            rp_d  = '0;
            fd_d  = 1'b0;
            lvl_d = 1'b0;
            rel_d = 1'b1;
          end else begin
            db_d = db_q + DB_ONE;
          end
        end
        default: begin
          st_d = RELEASED;
        end
      endcase
    end

    assign level_d[i]   = lvl_d;
    assign press_d[i]   = prs_d;
    assign release_d[i] = rel_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level     <= '0;
      btn_press     <= '0;
      btn_release   <= '0;
      btn_any_press <= 1'b0;
    end else begin
      btn_level     <= level_d;
      btn_press     <= press_d;
      btn_release   <= release_d;
      btn_any_press <= |press_d;
    end
  end

endmodule
